// File: rtl/dma_pkg.sv
// Shared types for the DMA responder.
// Status codes are also used by the accelerator register file.
package dma_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUS  = ST_BUS,
    RESP = ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK       = 2'd0,
    STAT_BUSERR   = 2'd1,
    STAT_TIMEOUT  = 2'd2,
    STAT_MISALIGN = 2'd3
  } status_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dma_timeout_ctr.sv
// Loadable down-counter bounding one Wishbone cycle.
// expired is high in the last allowed bus cycle.
module dma_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // load at cycle start, count down while the cycle runs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == W'(1));

endmodule

// File: rtl/dma_responder.sv
// DMA request to Wishbone classic master bridge.
// Every accepted request gets exactly one dma_ack.
module dma_responder
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA =
    DATA_WIDTH'(ERR_DATA_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic                  dma_we,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic                  err_flag,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  err_clr,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 :
                      $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t  state, state_d;
  status_t stat;
  logic    start, fin, fin_err;
  logic    ctr_exp, to_exp;
  logic    op_we;
  logic [ADDR_WIDTH-1:0] err_a;

  dma_timeout_ctr #(
    .W(TW)
  ) u_to (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .en       (state == BUS),
    .load_val (TW'(TIMEOUT_CYCLES)),
    .expired  (ctr_exp)
  );

  assign to_exp  = TO_EN && ctr_exp;
  assign fin_err = (stat != STAT_OK);
  assign op_we   = (state == IDLE) ? dma_we : wbm_we_o;
  assign err_a   = (state == IDLE) ? dma_addr : wbm_adr_o;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // next state; fin marks the edge that enters RESP
  always_comb begin
    state_d = state;
    start   = 1'b0;
    fin     = 1'b0;
    stat    = STAT_OK;
    unique case (state)
      IDLE: begin
        if (dma_req) begin
          if (dma_addr[1:0] == 2'b00) begin
            start   = 1'b1;
            state_d = BUS;
          end else begin
            fin     = 1'b1;
            stat    = STAT_MISALIGN;
            state_d = RESP;
          end
        end
      end
      BUS: begin
        if (wbm_err_i) begin
          fin     = 1'b1;
          stat    = STAT_BUSERR;
          state_d = RESP;
        end else if (to_exp) begin
          fin     = 1'b1;
          stat    = STAT_TIMEOUT;
          state_d = RESP;
        end else if (wbm_ack_i) begin
          fin     = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus master outputs, response and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      err_flag  <= 1'b0;
      err_addr  <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      dma_ack <= fin;
      if (start) begin
        wbm_adr_o <= dma_addr;
        wbm_dat_o <= dma_wdata;
        wbm_we_o  <= dma_we;
        wbm_sel_o <= 4'hF;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
      end else if (fin) begin
        wbm_sel_o <= 4'h0;
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
      end
      if (fin && !op_we) begin
        dma_rdata <= fin_err ? ERR_DATA : wbm_dat_i;
      end
      if (fin && !fin_err) begin
        if (op_we) wr_count <= sat_inc(wr_count);
        else       rd_count <= sat_inc(rd_count);
      end
      if (fin && fin_err) begin
        err_flag <= 1'b1;
        if (!err_flag || err_clr) err_addr <= err_a;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_responder.sv
// Directed bench for dma_responder.
// Wishbone slave model with wait states and error modes.
module tb_dma_responder;

  logic        clk;
  logic        rst_n;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic        dma_we;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        err_flag;
  logic [31:0] err_addr;
  logic        err_clr;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int n_chk;
  int n_err;

  // slave: mode 0 ack, 1 err, 2 silent, 3 ack+err
  int          sl_mode;
  int          sl_ws;
  int          wcnt;
  logic [31:0] wr_mem_addr;
  logic [31:0] wr_mem_data;

  dma_responder #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_we    (dma_we),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .err_flag  (err_flag),
    .err_addr  (err_addr),
    .err_clr   (err_clr),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic hit;
  assign hit = wbm_cyc_o && wbm_stb_o && (wcnt == sl_ws);
  assign wbm_ack_i = hit && (sl_mode == 0 || sl_mode == 3);
  assign wbm_err_i = hit && (sl_mode == 1 || sl_mode == 3);
  assign wbm_dat_i = (wbm_adr_o == 32'h100) ? 32'h12345678 :
                     {16'hC0DE, wbm_adr_o[15:0]};

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o) begin
      wcnt <= wcnt + 1;
      if (wbm_ack_i && !wbm_err_i && wbm_we_o) begin
        wr_mem_addr <= wbm_adr_o;
        wr_mem_data <= wbm_dat_o;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one request; n = cycles from the sampling edge to the ack cycle
  task automatic do_req(input logic [31:0] a,
                        input logic we,
                        input logic [31:0] wd,
                        output int n,
                        output logic saw_cyc);
    n = 0;
    saw_cyc = 1'b0;
    dma_req = 1'b1;
    dma_addr = a;
    dma_we = we;
    dma_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (wbm_cyc_o) saw_cyc = 1'b1;
      if (dma_ack) break;
    end
    chk("ack_seen", {31'b0, dma_ack}, 32'd1);
    dma_req = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, dma_ack}, 32'd0);
  endtask

  int          n;
  logic        sc;
  int          stab;
  int          acks;
  int          bad;
  logic [31:0] a;

  initial begin
    n_chk = 0;
    n_err = 0;
    sl_mode = 0;
    sl_ws = 0;
    rst_n = 1'b0;
    dma_req = 1'b0;
    dma_addr = '0;
    dma_we = 1'b0;
    dma_wdata = '0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("rst_ack", {31'b0, dma_ack}, 32'd0);
    chk("rst_rd", {16'b0, rd_count}, 32'd0);
    chk("rst_err", {31'b0, err_flag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-wait read
    do_req(32'h100, 1'b0, 32'h0, n, sc);
    chk("rd0_lat", 32'(n), 32'd2);
    chk("rd0_data", dma_rdata, 32'h12345678);
    chk("rd0_cnt", {16'b0, rd_count}, 32'd1);

    // write with 3 wait states, count stable bus cycles
    sl_ws = 3;
    stab = 0;
    dma_req = 1'b1;
    dma_addr = 32'h200;
    dma_we = 1'b1;
    dma_wdata = 32'hA5A5A5A5;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (wbm_cyc_o && wbm_stb_o && wbm_we_o &&
          wbm_adr_o == 32'h200 &&
          wbm_dat_o == 32'hA5A5A5A5 &&
          wbm_sel_o == 4'hF) stab++;
      if (dma_ack) break;
    end
    dma_req = 1'b0;
    chk("wr_lat", 32'(n), 32'd5);
    chk("wr_stable", 32'(stab), 32'd4);
    @(negedge clk);
    chk("wr_ack_once", {31'b0, dma_ack}, 32'd0);
    chk("wr_cnt", {16'b0, wr_count}, 32'd1);
    chk("wr_mem_a", wr_mem_addr, 32'h200);
    chk("wr_mem_d", wr_mem_data, 32'hA5A5A5A5);

    // 64 back-to-back reads with req held high
    sl_ws = 0;
    a = 32'h1000;
    acks = 0;
    bad = 0;
    dma_req = 1'b1;
    dma_we = 1'b0;
    dma_addr = a;
    for (int c = 0; c < 400 && acks < 64; c++) begin
      @(negedge clk);
      if (wbm_stb_o && wbm_adr_o !== a) bad++;
      if (dma_ack) begin
        if (dma_rdata !== {16'hC0DE, a[15:0]}) bad++;
        acks++;
        a = a + 32'd4;
        dma_addr = a;
      end
    end
    dma_req = 1'b0;
    @(negedge clk);
    chk("str_acks", 32'(acks), 32'd64);
    chk("str_bad", 32'(bad), 32'd0);
    chk("str_cnt", {16'b0, rd_count}, 32'd65);

    // bus error then timeout
    sl_mode = 1;
    do_req(32'h300, 1'b0, 32'h0, n, sc);
    chk("berr_lat", 32'(n), 32'd2);
    chk("berr_data", dma_rdata, 32'hDEADBEEF);
    chk("berr_flag", {31'b0, err_flag}, 32'd1);
    chk("berr_addr", err_addr, 32'h300);
    sl_mode = 2;
    do_req(32'h304, 1'b0, 32'h0, n, sc);
    chk("to_lat", 32'(n), 32'd9);
    chk("to_data", dma_rdata, 32'hDEADBEEF);
    chk("to_addr_kept", err_addr, 32'h300);
    chk("to_cnt", {16'b0, rd_count}, 32'd65);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_flag", {31'b0, err_flag}, 32'd0);

    // misaligned read: no bus cycle
    sl_mode = 0;
    do_req(32'h102, 1'b0, 32'h0, n, sc);
    chk("mis_lat", 32'(n), 32'd1);
    chk("mis_nocyc", {31'b0, sc}, 32'd0);
    chk("mis_flag", {31'b0, err_flag}, 32'd1);
    chk("mis_addr", err_addr, 32'h102);
    chk("mis_data", dma_rdata, 32'hDEADBEEF);

    // ack and err together: error wins
    sl_mode = 3;
    do_req(32'h108, 1'b0, 32'h0, n, sc);
    chk("ae_lat", 32'(n), 32'd2);
    chk("ae_data", dma_rdata, 32'hDEADBEEF);
    chk("ae_cnt", {16'b0, rd_count}, 32'd65);
    chk("ae_addr_kept", err_addr, 32'h102);

    // reset in the middle of a bus cycle
    sl_mode = 2;
    dma_req = 1'b1;
    dma_addr = 32'h400;
    dma_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_stb", {31'b0, wbm_stb_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("mid_stb0", {31'b0, wbm_stb_o}, 32'd0);
    chk("mid_ack", {31'b0, dma_ack}, 32'd0);
    chk("mid_rd", {16'b0, rd_count}, 32'd0);
    chk("mid_wr", {16'b0, wr_count}, 32'd0);
    dma_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sl_mode = 0;
    @(negedge clk);
    do_req(32'h100, 1'b0, 32'h0, n, sc);
    chk("post_lat", 32'(n), 32'd2);
    chk("post_data", dma_rdata, 32'h12345678);
    chk("post_cnt", {16'b0, rd_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
